// File: rtl/ahb_ext_sram.sv
// ahb_ext_sram: AHB-Lite subordinate on the external-bus port, backed by a
// word-organised SRAM with programmable wait states and byte-strobe writes.
// Optional build macro: EXTMEM_ERR_EN (out-of-range accesses get a two-cycle
// ERROR response; without it addresses alias modulo DEPTH and HRESPEXT is 0).
module ahb_ext_sram #(
   parameter int unsigned     AHBW    = 64,
   parameter int unsigned     PA_BITS = 34,
   parameter int unsigned     DEPTH   = 1024,
   parameter longint unsigned BASE    = 64'h8000_0000,
   parameter int unsigned     WAIT    = 0
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                HSELEXT,
   input  logic [PA_BITS-1:0]  HADDR,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [2:0]          HBURST,
   input  logic [1:0]          HTRANS,
   input  logic                HREADY,
   input  logic [AHBW-1:0]     HWDATA,
   input  logic [AHBW/8-1:0]   HWSTRB,
   output logic [AHBW-1:0]     HRDATAEXT,
   output logic                HREADYEXT,
   output logic                HRESPEXT
);

   localparam int unsigned         NBYTES  = AHBW / 8;
   localparam int unsigned         LSB     = $clog2(NBYTES);
   localparam int unsigned         IDX_W   = $clog2(DEPTH);
   localparam logic [PA_BITS-1:0]  BASE_A  = PA_BITS'(BASE);
   localparam logic [3:0]          WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

`ifdef EXTMEM_ERR_EN
   localparam longint unsigned     LIMIT   = BASE + 64'(DEPTH) * 64'(NBYTES);
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

   state_t               state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx_q;
   logic                 wr_q;
   logic                 accept, take, open, range_err;
   logic [PA_BITS-1:0]   addr_off;
   logic [IDX_W-1:0]     idx_a;
   logic [AHBW-1:0]      mem [DEPTH];
   logic                 unused_ok;

   assign addr_off  = HADDR - BASE_A;
   assign idx_a     = addr_off[LSB +: IDX_W];
   assign accept    = HSELEXT & HREADY & HTRANS[1];
   assign unused_ok = &{1'b0, HSIZE, HBURST, HTRANS[0], addr_off};

`ifdef EXTMEM_ERR_EN
   assign range_err = (64'(HADDR) < BASE) || (64'(HADDR) >= LIMIT);
`else
   assign range_err = 1'b0;
`endif

   // Next-state and wait counter; a new address phase is only taken in
   // cycles where this subordinate drives HREADYEXT high.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      open      = (state == ST_IDLE) || (state == ST_DATA);
`ifdef EXTMEM_ERR_EN
      open      = open || (state == ST_ERR2);
`endif
      take      = open && accept;
      case (state)
         ST_WAIT: begin
            if (cnt == '0) state_nxt = ST_DATA;
            else           cnt_nxt   = cnt - 4'd1;
         end
`ifdef EXTMEM_ERR_EN
         ST_ERR1: state_nxt = ST_ERR2;
`endif
         default: state_nxt = ST_IDLE;
      endcase
      if (take) begin
`ifdef EXTMEM_ERR_EN
         if (range_err) state_nxt = ST_ERR1;
         else
`endif
         if (WAIT == 0) state_nxt = ST_DATA;
         else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LD;
         end
      end
   end

   // State, counter and registered address-phase information.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx_q <= '0;
         wr_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (take) begin
            idx_q <= idx_a;
            wr_q  <= HWRITE;
         end
      end
   end

   // Byte-strobed write at the edge closing a write data phase.
   always_ff @(posedge HCLK) begin
      if (state == ST_DATA && wr_q) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   // Response outputs decoded from the current state.
   always_comb begin
      HREADYEXT = (state != ST_WAIT);
      HRESPEXT  = 1'b0;
`ifdef EXTMEM_ERR_EN
      if (state == ST_ERR1) HREADYEXT = 1'b0;
      HRESPEXT = (state == ST_ERR1) || (state == ST_ERR2);
`endif
   end

   // Read data only during a read data phase, zero otherwise.
   always_comb begin
      HRDATAEXT = '0;
      if (state == ST_DATA && !wr_q) HRDATAEXT = mem[idx_q];
   end

endmodule

// File: tb/tb_ahb_ext_sram.sv
`timescale 1ns/1ps
module tb_ahb_ext_sram;

   localparam int unsigned     AHBW    = 64;
   localparam int unsigned     PA_BITS = 34;
   localparam int unsigned     DEPTH   = 1024;
   localparam longint unsigned BASE    = 64'h8000_0000;
   localparam int              NI      = 3;
   localparam int              WAITS [NI] = '{0, 2, 3};

   typedef struct {
      bit                  wr;
      logic [PA_BITS-1:0]  addr;
      logic [63:0]         data;
      logic [7:0]          strb;
   } req_t;

   typedef struct {
      bit          rd;
      logic [63:0] data;
      logic        resp;
      int          stalls;
   } exp_t;

   logic                HCLK = 1'b0;
   logic                HRESETn;
   logic [NI-1:0]       sel;
   logic [PA_BITS-1:0]  haddr;
   logic                hwrite;
   logic [1:0]          htrans;
   logic [63:0]         hwdata;
   logic [7:0]          hwstrb;
   logic [63:0]         rdata [NI];
   logic [NI-1:0]       ready;
   logic [NI-1:0]       resp;

   int                  checks = 0;
   int                  errors = 0;
   req_t                req_q [$];
   exp_t                sb [$];
   logic [63:0]         mdl [int];

   always #5 HCLK = ~HCLK;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ahb_ext_sram #(
         .AHBW   (AHBW),
         .PA_BITS(PA_BITS),
         .DEPTH  (DEPTH),
         .BASE   (BASE),
         .WAIT   (WAITS[g])
      ) u_dut (
         .HCLK     (HCLK),
         .HRESETn  (HRESETn),
         .HSELEXT  (sel[g]),
         .HADDR    (haddr),
         .HWRITE   (hwrite),
         .HSIZE    (3'b011),
         .HBURST   (3'b000),
         .HTRANS   (htrans),
         .HREADY   (ready[g]),
         .HWDATA   (hwdata),
         .HWSTRB   (hwstrb),
         .HRDATAEXT(rdata[g]),
         .HREADYEXT(ready[g]),
         .HRESPEXT (resp[g])
      );
   end

   function automatic req_t mk(input bit wr, input longint unsigned a,
                               input logic [63:0] d, input logic [7:0] s);
      req_t r;
      r.wr = wr; r.addr = PA_BITS'(a); r.data = d; r.strb = s;
      return r;
   endfunction

   // Reference model: called when an address phase is accepted.
   function automatic void model_accept(input int k, input req_t r);
      logic [PA_BITS-1:0] off;
      int                 idx, key;
      bit                 err;
      exp_t               e;
      logic [63:0]        w;
      off = r.addr - PA_BITS'(BASE);
      idx = int'((off >> 3) % DEPTH);
      key = k * int'(DEPTH) + idx;
`ifdef EXTMEM_ERR_EN
      err = (64'(r.addr) < BASE) || (64'(r.addr) >= BASE + 64'(DEPTH) * 8);
`else
      err = 1'b0;
`endif
      e.rd = 1'b0; e.data = '0; e.resp = 1'b0; e.stalls = WAITS[k];
      if (err) begin
         e.resp = 1'b1;
         e.stalls = 1;
      end else if (r.wr) begin
         w = mdl.exists(key) ? mdl[key] : 64'hx;
         for (int b = 0; b < 8; b++)
            if (r.strb[b]) w[8*b +: 8] = r.data[8*b +: 8];
         mdl[key] = w;
      end else begin
         e.rd = 1'b1;
         e.data = mdl.exists(key) ? mdl[key] : 64'hx;
      end
      sb.push_back(e);
   endfunction

   // Pipelined AHB master for instance k; drains req_q, checks against sb.
   task automatic run_seq(input int k, input string tag, output int ncyc);
      bit    have_dp;
      req_t  dp, r;
      int    stall;
      exp_t  e;
      logic  rdy;
      have_dp = 1'b0; stall = 0; ncyc = 0;
      while ((req_q.size() != 0 || have_dp) && ncyc < 200) begin
         sel = '0;
         if (req_q.size() != 0) begin
            sel[k] = 1'b1; haddr = req_q[0].addr; hwrite = req_q[0].wr; htrans = 2'b10;
         end else begin
            htrans = 2'b00;
         end
         if (have_dp && dp.wr) begin
            hwdata = dp.data; hwstrb = dp.strb;
         end
         @(negedge HCLK);
         rdy = ready[k];
         if (have_dp) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL %s scoreboard_empty inst%0d", tag, k);
               have_dp = 1'b0;
            end else if (!rdy) begin
               stall++;
               checks++;
               if (resp[k] !== sb[0].resp || rdata[k] !== 64'h0) begin
                  errors++;
                  $display("FAIL %s stall_out inst%0d got resp=%b rdata=%h exp resp=%b rdata=0",
                           tag, k, resp[k], rdata[k], sb[0].resp);
               end
            end else begin
               e = sb.pop_front();
               checks++;
               if (resp[k] !== e.resp) begin
                  errors++;
                  $display("FAIL %s resp inst%0d got %b exp %b", tag, k, resp[k], e.resp);
               end
               checks++;
               if (stall != e.stalls) begin
                  errors++;
                  $display("FAIL %s stalls inst%0d got %0d exp %0d", tag, k, stall, e.stalls);
               end
               checks++;
               if (e.rd && rdata[k] !== e.data) begin
                  errors++;
                  $display("FAIL %s rdata inst%0d got %h exp %h", tag, k, rdata[k], e.data);
               end else if (!e.rd && rdata[k] !== 64'h0) begin
                  errors++;
                  $display("FAIL %s rdata_zero inst%0d got %h exp 0", tag, k, rdata[k]);
               end
               have_dp = 1'b0; stall = 0;
            end
         end
         if (rdy && req_q.size() != 0) begin
            r = req_q.pop_front();
            model_accept(k, r);
            dp = r; have_dp = 1'b1;
         end
         @(posedge HCLK); #1;
         ncyc++;
      end
      sel = '0; htrans = 2'b00;
      checks++;
      if (req_q.size() != 0 || have_dp) begin
         errors++;
         $display("FAIL %s timeout inst%0d got pending=%0d exp 0", tag, k, req_q.size());
         req_q.delete(); sb.delete();
      end
   endtask

   task automatic check_idle_out(input int k, input string tag);
      checks++;
      if (ready[k] !== 1'b1 || resp[k] !== 1'b0 || rdata[k] !== 64'h0) begin
         errors++;
         $display("FAIL %s inst%0d got ready=%b resp=%b rdata=%h exp ready=1 resp=0 rdata=0",
                  tag, k, ready[k], resp[k], rdata[k]);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0; sel = '0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
      hwdata = '0; hwstrb = '0;
      repeat (2) @(posedge HCLK);
      #1;
      for (int k = 0; k < NI; k++) check_idle_out(k, "reset_values");
      HRESETn = 1'b1;
      repeat (4) begin
         @(negedge HCLK);
         for (int k = 0; k < NI; k++) check_idle_out(k, "idle_bus");
      end
      @(posedge HCLK); #1;
   endtask

   task automatic test_write_read();
      int n;
      req_q.push_back(mk(1, BASE, 64'h1122334455667788, 8'hFF));
      req_q.push_back(mk(0, BASE, '0, '0));
      run_seq(0, "write_read", n);
   endtask

   task automatic test_partial_write();
      int n;
      req_q.push_back(mk(1, BASE, 64'hAAAAAAAA_BBBBBBBB, 8'h0F));
      req_q.push_back(mk(0, BASE, '0, '0));
      run_seq(0, "partial_write", n);
      checks++;
      if (mdl[0] !== 64'h11223344BBBBBBBB) begin
         errors++;
         $display("FAIL partial_model got %h exp 11223344bbbbbbbb", mdl[0]);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 1; i <= 4; i++)
         req_q.push_back(mk(1, BASE + 64'(8 * i), {$urandom(), $urandom()}, 8'(8'hFF >> (i - 1))));
      for (int i = 1; i <= 4; i++)
         req_q.push_back(mk(0, BASE + 64'(8 * i), '0, '0));
      run_seq(0, "back_to_back", n);
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL back_to_back_cycles got %0d exp 9", n);
      end
   endtask

   task automatic test_wait_states();
      int n;
      for (int k = 1; k < NI; k++) begin
         req_q.push_back(mk(1, BASE + 64'h100, 64'hDEADBEEF_0BADF00D + 64'(k), 8'hFF));
         req_q.push_back(mk(0, BASE + 64'h100, '0, '0));
         run_seq(k, "wait_states", n);
         checks++;
         if (n != 1 + 2 * (WAITS[k] + 1)) begin
            errors++;
            $display("FAIL wait_cycles inst%0d got %0d exp %0d", k, n, 1 + 2 * (WAITS[k] + 1));
         end
      end
   endtask

   task automatic test_range();
      int n;
      req_q.push_back(mk(1, BASE + 64'(8 * (DEPTH - 1)), 64'h0123456789ABCDEF, 8'hFF));
      req_q.push_back(mk(1, BASE - 64'd8, 64'hFEDCBA9876543210, 8'hFF));
      req_q.push_back(mk(0, BASE + 64'(8 * DEPTH), '0, '0));
      req_q.push_back(mk(0, BASE + 64'(8 * (DEPTH - 1)), '0, '0));
      req_q.push_back(mk(0, BASE, '0, '0));
      run_seq(0, "range", n);
   endtask

   task automatic test_reset_mid_write();
      int n;
      req_q.push_back(mk(1, BASE + 64'h200, 64'h5555AAAA5555AAAA, 8'hFF));
      run_seq(1, "rst_pre_write", n);
      sel = '0; sel[1] = 1'b1; haddr = PA_BITS'(BASE + 64'h200); hwrite = 1'b1; htrans = 2'b10;
      @(posedge HCLK); #1;
      sel = '0; htrans = 2'b00; hwdata = 64'h0F0F0F0F0F0F0F0F; hwstrb = 8'hFF;
      @(negedge HCLK);
      checks++;
      if (ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL rst_stall1 got ready=%b exp 0", ready[1]);
      end
      @(posedge HCLK); #1;
      HRESETn = 1'b0;
      #1;
      check_idle_out(1, "rst_mid_write");
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      req_q.push_back(mk(0, BASE + 64'h200, '0, '0));
      run_seq(1, "rst_post_read", n);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_back_to_back();
      test_wait_states();
      test_range();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
